// File: rtl/drac_pkg.sv
// Shared core request types seen by the prefetch path.
package drac_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] data_rs1;
    logic [63:0] data_rs2;
    logic [4:0]  rd;
    logic [3:0]  mem_size;
    logic [7:0]  mem_op;
  } req_cpu_dcache_t;

endpackage

// File: rtl/hwpf_pkg.sv
// Types and defaults for the hardware prefetch request queue.
package hwpf_pkg;
  import drac_pkg::*;

  localparam int HWPF_Q_DEPTH_DEFAULT = 8;
  // Tags are stored zero-extended to a fixed width so the entry type stays non-parameterised.
  localparam int HWPF_TID_W_MAX = 16;

  typedef logic [HWPF_TID_W_MAX-1:0] hwpf_tid_t;

  typedef struct packed {
    logic            valid;
    hwpf_tid_t       tid;
    req_cpu_dcache_t req;
  } hwpf_entry_t;

  function automatic hwpf_entry_t hwpf_make_entry(input hwpf_tid_t tid, input req_cpu_dcache_t req);
    hwpf_entry_t e;
    e.valid = 1'b1;
    e.tid   = tid;
    e.req   = req;
    return e;
  endfunction

endpackage

// File: rtl/hwpf_compact.sv
// Order-preserving compactor: kept entries slide toward slot 0, survivor count reported.
module hwpf_compact
  import hwpf_pkg::*;
#(
  parameter int DEPTH = HWPF_Q_DEPTH_DEFAULT,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  hwpf_entry_t      entries   [DEPTH],
  input  logic [DEPTH-1:0] keep,
  output hwpf_entry_t      compacted [DEPTH],
  output logic [CW-1:0]    count
);

  // pos_reg[i] is the number of kept entries strictly before slot i (its destination slot).
  logic [CW-1:0] pos [DEPTH+1];

  assign pos[0] = '0;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_prefix
    assign pos[gi+1] = pos[gi] + CW'(keep[gi]);
  end

  assign count = pos[DEPTH];

  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      compacted[j] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (keep[i] && (pos[i] == CW'(j))) compacted[j] = entries[i];
      end
    end
  end

endmodule

// File: rtl/hwpf_req_queue.sv
// Collapsing age-ordered prefetch request queue feeding the dcache arbiter.
module hwpf_req_queue
  import drac_pkg::*;
  import hwpf_pkg::*;
#(
  parameter int DEPTH            = HWPF_Q_DEPTH_DEFAULT,
  parameter int TID_W            = 7,
  parameter bit OVERWRITE_OLDEST = 1'b0,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             enable_i,
  input  logic             take_req_i,
  input  logic [TID_W-1:0] tid_req_i,
  input  req_cpu_dcache_t  cpu_req_i,
  input  logic             read_i,
  input  logic             remove_element_i,
  input  logic [TID_W-1:0] tid_remove_element_i,
  output logic             arbiter_req_valid_o,
  output req_cpu_dcache_t  arbiter_req_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  hwpf_entry_t      q_reg  [DEPTH];
  hwpf_entry_t      q_next [DEPTH];
  logic [CW-1:0]    count_reg, count_next;
  logic             drop_reg, drop_next;

  hwpf_entry_t      kept   [DEPTH];
  hwpf_entry_t      evict  [DEPTH];
  logic [CW-1:0]    kept_cnt, evict_cnt, base_cnt;
  logic [DEPTH-1:0] keep_mask, evict_mask;

  hwpf_tid_t        tid_push, tid_rm;
  logic             pop, push_ok, room, do_evict;

  assign tid_push = hwpf_tid_t'(tid_req_i);
  assign tid_rm   = hwpf_tid_t'(tid_remove_element_i);

  assign arbiter_req_valid_o = q_reg[0].valid & enable_i;
  assign arbiter_req_o       = arbiter_req_valid_o ? q_reg[0].req : '0;
  assign count_o             = count_reg;
  assign full_o              = (count_reg == CW'(DEPTH));
  assign empty_o             = (count_reg == '0);
  assign drop_o              = drop_reg;

  assign pop = read_i & arbiter_req_valid_o;

  // A head that is both popped and tag-removed simply clears one keep bit.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mask
    assign keep_mask[gi]  = q_reg[gi].valid
                          & ~(remove_element_i & (q_reg[gi].tid == tid_rm))
                          & ~(pop & (gi == 0));
    assign evict_mask[gi] = kept[gi].valid & (gi != 0);
  end

  hwpf_compact #(.DEPTH(DEPTH)) u_compact_keep (
    .entries   (q_reg),
    .keep      (keep_mask),
    .compacted (kept),
    .count     (kept_cnt)
  );

  // Second pass drops the oldest survivor to make room when evicting.
  hwpf_compact #(.DEPTH(DEPTH)) u_compact_evict (
    .entries   (kept),
    .keep      (evict_mask),
    .compacted (evict),
    .count     (evict_cnt)
  );

  assign push_ok  = take_req_i & enable_i
                  & ~(remove_element_i & (tid_req_i == tid_remove_element_i));
  assign room     = (kept_cnt < CW'(DEPTH));
  assign do_evict = push_ok & ~room & OVERWRITE_OLDEST;

  always_comb begin
    base_cnt = do_evict ? evict_cnt : kept_cnt;
    for (int i = 0; i < DEPTH; i++) q_next[i] = do_evict ? evict[i] : kept[i];
    count_next = base_cnt;
    drop_next  = push_ok & ~room;
    if (push_ok && (room || do_evict)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == base_cnt) q_next[i] = hwpf_make_entry(tid_push, cpu_req_i);
      end
      count_next = base_cnt + CW'(1);
    end
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) q_next[i] = '0;
      count_next = '0;
      drop_next  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
      count_reg <= '0;
      drop_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
      count_reg <= count_next;
      drop_reg  <= drop_next;
    end
  end

endmodule

// File: tb/tb_hwpf_req_queue.sv
// Randomised and directed bench for hwpf_req_queue, drop-newest and evict-oldest builds side by side.
module tb_hwpf_req_queue;
  import drac_pkg::*;
  import hwpf_pkg::*;

  localparam int DEPTH = 8;
  localparam int TID_W = 7;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic             flush_i, enable_i, take_req_i, read_i, remove_element_i;
  logic [TID_W-1:0] tid_req_i, tid_remove_element_i;
  req_cpu_dcache_t  cpu_req_i;

  logic [1:0]          vld, full, empty, drop;
  logic [1:0][CW-1:0]  cnt;
  req_cpu_dcache_t [1:0] rq;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  hwpf_req_queue #(.DEPTH(DEPTH), .TID_W(TID_W), .OVERWRITE_OLDEST(1'b0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .enable_i(enable_i),
    .take_req_i(take_req_i), .tid_req_i(tid_req_i), .cpu_req_i(cpu_req_i),
    .read_i(read_i), .remove_element_i(remove_element_i),
    .tid_remove_element_i(tid_remove_element_i),
    .arbiter_req_valid_o(vld[0]), .arbiter_req_o(rq[0]), .count_o(cnt[0]),
    .full_o(full[0]), .empty_o(empty[0]), .drop_o(drop[0])
  );

  hwpf_req_queue #(.DEPTH(DEPTH), .TID_W(TID_W), .OVERWRITE_OLDEST(1'b1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .enable_i(enable_i),
    .take_req_i(take_req_i), .tid_req_i(tid_req_i), .cpu_req_i(cpu_req_i),
    .read_i(read_i), .remove_element_i(remove_element_i),
    .tid_remove_element_i(tid_remove_element_i),
    .arbiter_req_valid_o(vld[1]), .arbiter_req_o(rq[1]), .count_o(cnt[1]),
    .full_o(full[1]), .empty_o(empty[1]), .drop_o(drop[1])
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each queue is a plain list, index 0 oldest; k=1 is the evicting build.
  logic [TID_W-1:0] m_tid [2][DEPTH];
  req_cpu_dcache_t  m_req [2][DEPTH];
  int               m_n   [2] = '{0, 0};
  bit               m_drop[2] = '{0, 0};
  logic [TID_W-1:0] t_tid [DEPTH];
  req_cpu_dcache_t  t_req [DEPTH];
  int               n;
  bit               popm;

  always @(posedge clk_i or negedge rst_ni) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_ni || flush_i) begin
        m_n[k]    = 0;
        m_drop[k] = 1'b0;
      end else begin
        popm = (m_n[k] > 0) && enable_i && read_i;
        n = 0;
        for (int i = 0; i < m_n[k]; i++) begin
          if (!(remove_element_i && m_tid[k][i] == tid_remove_element_i) && !(i == 0 && popm)) begin
            t_tid[n] = m_tid[k][i];
            t_req[n] = m_req[k][i];
            n++;
          end
        end
        m_drop[k] = 1'b0;
        if (take_req_i && enable_i && !(remove_element_i && tid_req_i == tid_remove_element_i)) begin
          if (n == DEPTH) begin
            m_drop[k] = 1'b1;
            if (k == 1) begin
              for (int i = 0; i < DEPTH - 1; i++) begin
                t_tid[i] = t_tid[i+1];
                t_req[i] = t_req[i+1];
              end
              n--;
            end
          end
          if (n < DEPTH) begin
            t_tid[n] = tid_req_i;
            t_req[n] = cpu_req_i;
            n++;
          end
        end
        m_n[k] = n;
        for (int i = 0; i < n; i++) begin
          m_tid[k][i] = t_tid[i];
          m_req[k][i] = t_req[i];
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        bit ev;
        req_cpu_dcache_t er;
        ev = (m_n[k] > 0) && enable_i;
        er = ev ? m_req[k][0] : '0;
        chk($sformatf("dut%0d.valid", k), 256'(vld[k]), 256'(ev));
        chk($sformatf("dut%0d.req", k), 256'(rq[k]), 256'(er));
        chk($sformatf("dut%0d.count", k), 256'(cnt[k]), 256'(m_n[k]));
        chk($sformatf("dut%0d.full", k), 256'(full[k]), 256'(m_n[k] == DEPTH));
        chk($sformatf("dut%0d.empty", k), 256'(empty[k]), 256'(m_n[k] == 0));
        chk($sformatf("dut%0d.drop", k), 256'(drop[k]), 256'(m_drop[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_set(input int tid, input logic [63:0] d);
    take_req_i         = 1'b1;
    tid_req_i          = TID_W'(tid);
    cpu_req_i          = '0;
    cpu_req_i.valid    = 1'b1;
    cpu_req_i.data_rs1 = d;
    cpu_req_i.rd       = 5'd1;
  endtask

  task automatic idle();
    take_req_i = 1'b0; read_i = 1'b0; remove_element_i = 1'b0; flush_i = 1'b0;
  endtask

  int t5_tid [8] = '{0, 1, 2, 3, 4, 2, 6, 7};
  int t5_left[5] = '{1, 3, 4, 6, 7};

  initial begin
    flush_i = 1'b0; enable_i = 1'b1; take_req_i = 1'b0; read_i = 1'b0;
    remove_element_i = 1'b0; tid_req_i = '0; tid_remove_element_i = '0; cpu_req_i = '0;
    cmp_en = 1'b1;
    repeat (2) tick();
    chk("reset_empty", 256'(empty[0]), 256'(1));
    chk("reset_count", 256'(cnt[0]), 256'(0));
    rst_ni = 1'b1;

    // Single push then pop, no same-cycle bypass.
    push_set(1, 64'hCAFECAFE);
    read_i = 1'b1;
    #1 chk("t1_no_bypass", 256'(vld[0]), 256'(0));
    tick();
    take_req_i = 1'b0;
    chk("t1_valid", 256'(vld[0]), 256'(1));
    chk("t1_data", 256'(rq[0].data_rs1), 256'(64'hCAFECAFE));
    chk("t1_rd", 256'(rq[0].rd), 256'(1));
    tick();
    chk("t1_valid_after_pop", 256'(vld[0]), 256'(0));
    chk("t1_count_after_pop", 256'(cnt[0]), 256'(0));
    idle();

    // Pop and push together.
    push_set(2, 64'h1BEEF);
    tick();
    push_set(3, 64'h3);
    read_i = 1'b1;
    chk("t2_head_old", 256'(rq[0].data_rs1), 256'(64'h1BEEF));
    tick();
    idle();
    chk("t2_head_new", 256'(rq[0].data_rs1), 256'(3));
    chk("t2_count", 256'(cnt[0]), 256'(1));
    chk("t2_drop", 256'(drop[0]), 256'(0));
    read_i = 1'b1;
    tick();
    idle();

    // Overfill: drop-newest vs evict-oldest.
    for (int i = 0; i < 10; i++) begin
      push_set(i, 64'(i));
      tick();
      if (i == 7) begin
        chk("t3_full", 256'(full[0]), 256'(1));
        chk("t3_no_drop_at_8", 256'(drop[0]), 256'(0));
      end
      if (i >= 8) begin
        chk("t3_drop", 256'(drop[0]), 256'(1));
        chk("t4_drop", 256'(drop[1]), 256'(1));
      end
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      read_i = 1'b1;
      chk("t3_pop_order", 256'(rq[0].data_rs1), 256'(i));
      chk("t4_pop_order", 256'(rq[1].data_rs1), 256'(i + 2));
      tick();
    end
    idle();
    chk("t3_empty", 256'(empty[0]), 256'(1));
    chk("t4_empty", 256'(empty[1]), 256'(1));

    // Remove duplicated tid together with a pop.
    for (int i = 0; i < 8; i++) begin
      push_set(t5_tid[i], 64'(32'h100 + i));
      tick();
    end
    idle();
    remove_element_i = 1'b1; tid_remove_element_i = 7'd2; read_i = 1'b1;
    tick();
    idle();
    chk("t5_count0", 256'(cnt[0]), 256'(5));
    chk("t5_count1", 256'(cnt[1]), 256'(5));
    for (int i = 0; i < 5; i++) begin
      read_i = 1'b1;
      chk("t5_order", 256'(rq[0].data_rs1), 256'(32'h100 + t5_left[i]));
      tick();
    end
    idle();

    // Flush beats a simultaneous push.
    for (int i = 0; i < 4; i++) begin
      push_set(i, 64'(i));
      tick();
    end
    push_set(5, 64'h55);
    flush_i = 1'b1;
    tick();
    idle();
    chk("t6_flush_empty", 256'(empty[0]), 256'(1));
    chk("t6_flush_valid", 256'(vld[0]), 256'(0));
    chk("t6_flush_req", 256'(rq[0]), 256'(0));

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      push_set(i, 64'(i));
      tick();
    end
    idle();
    rst_ni = 1'b0;
    #2;
    chk("t6_rst_valid", 256'(vld[0]), 256'(0));
    chk("t6_rst_count", 256'(cnt[0]), 256'(0));
    chk("t6_rst_empty", 256'(empty[0]), 256'(1));
    tick();
    rst_ni = 1'b1;

    // Disabled queue ignores pushes.
    enable_i = 1'b0;
    push_set(9, 64'h9);
    tick();
    idle();
    chk("disabled_push", 256'(cnt[0]), 256'(0));
    enable_i = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst_ni               = ($urandom_range(0, 499) != 0);
      enable_i             = ($urandom_range(0, 9) != 0);
      flush_i              = ($urandom_range(0, 49) == 0);
      remove_element_i     = ($urandom_range(0, 11) == 0);
      tid_remove_element_i = TID_W'($urandom_range(0, 3));
      read_i               = ($urandom_range(0, 9) < 4);
      push_set($urandom_range(0, 3), {$urandom, $urandom});
      take_req_i           = ($urandom_range(0, 9) < 6);
      cpu_req_i.rd         = 5'($urandom);
      tick();
    end
    rst_ni = 1'b1;
    idle();
    tick();
    @(negedge clk_i);
    #1 cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hwpf_req_queue.md
Name: hwpf_req_queue

Overview:
- Parametrised prefetch-request queue between the next-line prefetcher's request capture and the dcache request arbiter.
- Buffers CPU-derived prefetch requests in age order and presents the oldest to the arbiter.
- Supports removing every entry that matches a tag id, flush, and enable gating.
- Adds a selectable full policy (drop newest / evict oldest), occupancy reporting and a drop pulse.

Parameters:
- DEPTH, 8, number of entries; any value >= 2, power of two not required.
- TID_W, 7, width of the tag id used for matching and removal.
- OVERWRITE_OLDEST, 0, full policy: 0 = drop incoming request; 1 = evict oldest entry and accept incoming request.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  invalidate all entries.
- enable_i  in  1  when 0: pushes ignored, valid_o forced 0, contents held.
- take_req_i  in  1  push request.
- tid_req_i  in  TID_W  tag id of the pushed request.
- cpu_req_i  in  req_cpu_dcache_t  pushed payload.
- read_i  in  1  arbiter ready; pops the head when valid_o is high.
- remove_element_i  in  1  remove all entries whose tid matches.
- tid_remove_element_i  in  TID_W  tid to remove.
- arbiter_req_valid_o  out  1  head entry valid.
- arbiter_req_o  out  req_cpu_dcache_t  head payload; '0 when not valid.
- count_o  out  $clog2(DEPTH+1)  occupancy.
- full_o  out  1  count_o == DEPTH.
- empty_o  out  1  count_o == 0.
- drop_o  out  1  one-cycle pulse when a request is lost (incoming dropped or oldest evicted).

Behaviour:
- Reset (async, rst_ni = 0): all entry valids cleared, count_o = 0, empty_o = 1, full_o = 0, drop_o = 0, arbiter_req_valid_o = 0, arbiter_req_o = '0. Reset mid-operation discards all contents immediately.
- Storage is a collapsing queue: slot 0 is the oldest, and valid slots are always contiguous from slot 0.
- Outputs:
  - arbiter_req_valid_o = slot0.valid & enable_i.
  - arbiter_req_o = slot0.payload when arbiter_req_valid_o is 1, else '0.
  - count_o, full_o and empty_o are registered-state derived; drop_o is registered.
- Latency: a push at edge N is visible on the outputs after edge N (one-cycle latency). There is no same-cycle bypass: with the queue empty, arbiter_req_valid_o is 0 in the cycle take_req_i is high.
- Per-cycle evaluation order, all applied at one edge:
  1. flush_i: next state is empty. Push, pop and remove are ignored; drop_o = 0.
  2. remove_element_i: every valid entry with tid == tid_remove_element_i is marked for deletion, including the head.
  3. Pop: if read_i & arbiter_req_valid_o, the head is deleted. If the head was also removed in step 2, it is deleted once only.
  4. Compaction: surviving entries shift toward slot 0, preserving order.
  5. Push, if take_req_i & enable_i:
     - If remove_element_i is high and tid_req_i == tid_remove_element_i, the push is discarded silently (drop_o = 0).
     - Else, if there is space after compaction, the request is written to the first free slot.
     - Else, with OVERWRITE_OLDEST = 0, the incoming request is lost and drop_o = 1.
     - Else, with OVERWRITE_OLDEST = 1, the compacted slot 0 is evicted, the rest shift down, the request is appended and drop_o = 1.
- A simultaneous pop and push on a full queue is always accepted with no drop.
- Duplicate tids are allowed; remove deletes all of them.
- While enable_i = 0, remove and flush still act.

Decomposition:
- drac_pkg already provides req_cpu_dcache_t.
- Add to the hwpf package:
  - hwpf_entry_t {valid, tid[TID_W], req}.
  - HWPF_Q_DEPTH_DEFAULT.
- One sub-module: hwpf_compact.
  - Combinational keep-mask plus prefix-count compactor.
  - Input: DEPTH entries and a keep mask. Output: compacted entries and the survivor count.
  - Reused by the evict path.

Test Plan:
1. Reset, enable_i = 1, push tid 1 / data_rs1 0xCAFECAFE, then read_i = 1 -> next cycle valid = 1, rd = 1, data_rs1 = 0xCAFECAFE. Following cycle valid = 0, count_o = 0.
2. Queue holds tid 2 / 0x1BEEF; same cycle push tid 3 and read_i = 1 -> head tid 2 popped, then tid 3 at head, count_o = 1, drop_o = 0.
3. OVERWRITE_OLDEST = 0, push tids 0..9 with read_i = 0 -> full_o after 8 pushes, drop_o high on pushes 8 and 9. Pops then return tids 0..7 in order, then empty_o = 1.
4. OVERWRITE_OLDEST = 1, push tids 0..9 -> pops return tids 2..9, drop_o pulsed twice.
5. Fill with tids 0..7, duplicate tid 2 at slot 5 via a second fill: remove tid 2 together with a pop -> both tid-2 entries and the head gone, order preserved, count decremented by 3.
6. Fill with 4 entries, flush_i = 1 together with a push -> next cycle empty_o = 1, valid = 0, arbiter_req_o = '0. Repeat with rst_ni pulsed low mid-stream -> outputs cleared asynchronously.
